powerup_sprite: RTL

Parametrised power-up item controller: the next generation of the mushroom sprite. It spawns from a question block when Mario bumps it inside a background-scroll window, then rises out of the block, walks with edge reversal, falls under gravity and lands. It is consumed when it overlaps Mario. It sits beside the Mario and background sprite blocks, drives `is_item` and a sprite-ROM read address for the colour mux, and reports `item_eaten` to the game-state logic.

---
 rtl/powerup_sprite.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/powerup_sprite.sv
// Power-up item controller: spawns from a question block, emerges, walks, falls, lands and is
// consumed on contact with Mario. Drives the pixel hit flag and sprite-ROM address.
module powerup_sprite #(
  parameter int unsigned X_HOME      = 305,
  parameter int unsigned Y_HOME      = 243,
  parameter int unsigned SIZE        = 32,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned STEP_MIN    = 45,
  parameter int unsigned STEP_MAX    = 65,
  parameter int unsigned GROUND_Y    = 420,
  parameter int unsigned X_MIN       = 0,
  parameter int unsigned X_MAX       = 607,
  parameter int unsigned WALK_STEP   = 2,
  parameter int unsigned FALL_STEP   = 4,
  parameter int unsigned RISE_STEP   = 2,
  parameter int unsigned TICK_DIV    = 3_000_000,
  parameter int unsigned MARIO_W     = 32,
  parameter int unsigned MARIO_H     = 32,
  parameter int unsigned ROM_BASE_X  = 158,
  parameter int unsigned ROM_BASE_Y  = 115,
  parameter int unsigned ROM_W       = 188
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        dead_reset,
  input  logic [8:0]  BG_step,
  input  logic        is_mario_up,
  input  logic        can_down,
  input  logic [9:0]  mario_x,
  input  logic [9:0]  mario_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        is_item,
  output logic [18:0] rom_addr,
  output logic        item_eaten,
  output logic [9:0]  item_x,
  output logic [9:0]  item_y
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {StIdle, StEmerge, StWalk, StFall, StEaten} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [9:0]      x_q, x_d, y_q, y_d, rise_q, rise_d;
  logic            dir_q, dir_d, pending_q, pending_d;
  logic            tick, bump_ok, active, hit;
  logic [10:0]     rise_next;
  logic [11:0]     ix, iy, mx, my;

  assign tick    = (cnt_q == CntW'(TICK_DIV - 1));
  assign bump_ok = is_mario_up && (BG_step >= 9'(STEP_MIN)) && (BG_step <= 9'(STEP_MAX));
  assign active  = (state_q == StEmerge) || (state_q == StWalk) || (state_q == StFall);

  // Strict AABB overlap, widened so the box sums cannot wrap.
  assign ix  = 12'(x_q);
  assign iy  = 12'(y_q);
  assign mx  = 12'(mario_x);
  assign my  = 12'(mario_y);
  assign hit = active && (ix < mx + 12'(MARIO_W)) && (mx < ix + 12'(SIZE)) &&
               (iy < my + 12'(MARIO_H)) && (my < iy + 12'(SIZE));

  always_ff @(posedge Clk) begin
    if (Reset || dead_reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      x_q       <= 10'(X_HOME);
      y_q       <= 10'(Y_HOME);
      rise_q    <= '0;
      dir_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rise_q    <= rise_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + CntW'(1);
    x_d       = x_q;
    y_d       = y_q;
    rise_d    = rise_q;
    dir_d     = dir_q;
    pending_d = pending_q;
    rise_next = 11'(rise_q) + 11'(RISE_STEP);
    unique case (state_q)
      StIdle: begin
        if (bump_ok) pending_d = 1'b1;
        if (tick && pending_q) begin
          state_d   = StEmerge;
          pending_d = 1'b0;
        end
      end
      StEmerge: if (tick) begin
        rise_d = rise_next[9:0];
        if (rise_next >= 11'(SIZE)) begin
          y_d     = 10'(Y_HOME - SIZE);
          state_d = StWalk;
          dir_d   = 1'b0;
        end else begin
          y_d = y_q - 10'(RISE_STEP);
        end
      end
      StWalk: if (tick) begin
        if (can_down) begin
          state_d = StFall;
        end else if (!dir_q) begin
          // Reaching the bound already counts as a wall hit.
          if (11'(x_q) + 11'(WALK_STEP) >= 11'(X_MAX)) begin
            x_d   = 10'(X_MAX);
            dir_d = 1'b1;
          end else begin
            x_d = x_q + 10'(WALK_STEP);
          end
        end else if (11'(x_q) <= 11'(X_MIN) + 11'(WALK_STEP)) begin
          x_d   = 10'(X_MIN);
          dir_d = 1'b0;
        end else begin
          x_d = x_q - 10'(WALK_STEP);
        end
      end
      StFall: if (tick) begin
        if (11'(y_q) + 11'(SIZE) + 11'(FALL_STEP) >= 11'(GROUND_Y)) begin
          y_d     = 10'(GROUND_Y - SIZE);
          state_d = StWalk;
        end else begin
          y_d = y_q + 10'(FALL_STEP);
        end
      end
      StEaten: ;
      default: state_d = StIdle;
    endcase
    if (hit) begin
      state_d = StEaten;
      x_d     = x_q;
      y_d     = y_q;
      rise_d  = rise_q;
      dir_d   = dir_q;
    end
  end

  logic [9:0]  dx, dy, tx_full, tx, ty;
  logic [18:0] addr;

  always_comb begin
    dx      = DrawX - x_q;
    dy      = DrawY - y_q;
    is_item = active && (DrawX >= x_q) && (DrawY >= y_q) &&
              (dx < 10'(SIZE)) && (dy < 10'(SIZE)) &&
              ((state_q != StEmerge) || (DrawY < 10'(Y_HOME)));
    tx_full = dir_q ? (10'(SIZE - 1) - dx) : dx;
    tx      = tx_full >> SCALE_SHIFT;
    ty      = dy >> SCALE_SHIFT;
    addr    = (19'(ROM_BASE_X) + 19'(tx)) + (19'(ROM_BASE_Y) + 19'(ty)) * 19'(ROM_W);
    rom_addr   = is_item ? addr : '0;
    item_eaten = (state_q == StEaten);
    item_x     = x_q;
    item_y     = y_q;
  end

endmodule
